// File: rtl/pulse_rate_gen.sv
// Programmable pulse-train generator: emits exactly `rate` evenly spread pulses per CLK_HZ-cycle window.
// Optional pulse counter feeding pulses_sent is built only when PULSE_RATE_GEN_COUNT_EN is defined.
module pulse_rate_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned CNT_W   = 23,
    parameter int unsigned TIMER_W = 26,
    parameter int unsigned ACC_W   = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] rate_in,
    input  logic             load,
    input  logic             stop,
    output logic             pulse_out,
    output logic             window_done,
    output logic             busy,
    output logic [CNT_W-1:0] pulses_sent
);

    localparam logic [ACC_W-1:0]   CLK_LIM    = ACC_W'(CLK_HZ);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLK_HZ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   rate;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   pend;
    logic               pend_vld;
    logic [TIMER_W-1:0] timer;

    logic [ACC_W-1:0]   sum_c;
    logic               fire_c;
    logic               win_end_c;

    // Requests at or above CLK_HZ saturate to one pulse per cycle.
    function automatic logic [ACC_W-1:0] clamp_rate(input logic [CNT_W-1:0] r);
        if (ACC_W'(r) >= CLK_LIM) return CLK_LIM;
        return ACC_W'(r);
    endfunction

    always_comb begin
        sum_c     = acc + rate;
        fire_c    = (sum_c >= CLK_LIM);
        win_end_c = (timer == TIMER_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rate        <= '0;
            acc         <= '0;
            pend        <= '0;
            pend_vld    <= 1'b0;
            timer       <= '0;
            pulse_out   <= 1'b0;
            window_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pulse_out   <= 1'b0;
            window_done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                busy     <= 1'b0;
                timer    <= '0;
                acc      <= '0;
                pend     <= '0;
                pend_vld <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            rate  <= clamp_rate(rate_in);
                            timer <= '0;
                            acc   <= '0;
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        pulse_out <= fire_c;
                        acc       <= fire_c ? (sum_c - CLK_LIM) : sum_c;
                        if (load) begin
                            pend     <= clamp_rate(rate_in);
                            pend_vld <= 1'b1;
                        end
                        // Window boundary: the only point where a new rate may take effect.
                        if (win_end_c) begin
                            window_done <= 1'b1;
                            timer       <= '0;
                            acc         <= '0;
                            if (load) begin
                                rate     <= clamp_rate(rate_in);
                                pend_vld <= 1'b0;
                            end else if (pend_vld) begin
                                rate     <= pend;
                                pend_vld <= 1'b0;
                            end
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PULSE_RATE_GEN_COUNT_EN
    logic [CNT_W-1:0] cnt;

    // Pulse count of the running window; pulses_sent includes a pulse fired on the closing edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            pulses_sent <= '0;
        end else if (stop) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (load) cnt <= '0;
        end else if (win_end_c) begin
            pulses_sent <= cnt + CNT_W'(fire_c);
            cnt         <= '0;
        end else if (fire_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign pulses_sent = '0;
`endif

endmodule

// File: tb/tb_pulse_rate_gen.sv
// Self-checking bench for pulse_rate_gen (CLK_HZ=10) against a closed-form window model.
module tb_pulse_rate_gen;

    localparam int unsigned HZ = 10;
    localparam int unsigned CW = 5;
    localparam int unsigned TW = 4;
    localparam int unsigned AW = 6;
`ifdef PULSE_RATE_GEN_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] rate_in = '0;
    logic          pulse_out;
    logic          window_done;
    logic          busy;
    logic [CW-1:0] pulses_sent;

    int total = 0;
    int bad   = 0;

    // Reference state: a window of rate r puts pulse k (1..HZ) where floor(k*r/HZ) steps up.
    bit m_run = 0;
    int m_rate = 0, m_pend = 0, m_k = 0, m_cnt = 0, m_sent = 0;
    bit m_pend_v = 0;
    bit exp_pulse = 0, exp_wd = 0;
    int obs_pulses = 0;

    pulse_rate_gen #(
        .CLK_HZ (HZ),
        .CNT_W  (CW),
        .TIMER_W(TW),
        .ACC_W  (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rate_in    (rate_in),
        .load       (load),
        .stop       (stop),
        .pulse_out  (pulse_out),
        .window_done(window_done),
        .busy       (busy),
        .pulses_sent(pulses_sent)
    );

    always #5 clk = ~clk;

    function automatic int clampf(input int r);
        return (r >= int'(HZ)) ? int'(HZ) : r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/pulse_out"}, 32'(pulse_out), 32'(exp_pulse));
        chk({tag, "/window_done"}, 32'(window_done), 32'(exp_wd));
        chk({tag, "/busy"}, 32'(busy), 32'(m_run));
        chk({tag, "/pulses_sent"}, 32'(pulses_sent), COUNT_EN ? 32'(m_sent) : 32'd0);
    endtask

    task automatic model_reset();
        m_run = 0; m_rate = 0; m_pend = 0; m_pend_v = 0;
        m_k = 0; m_cnt = 0; m_sent = 0; exp_pulse = 0; exp_wd = 0;
    endtask

    task automatic model_edge(input bit l, input bit s, input int r);
        exp_pulse = 0;
        exp_wd    = 0;
        if (s) begin
            m_run = 0; m_k = 0; m_cnt = 0; m_pend_v = 0;
        end else if (!m_run) begin
            if (l) begin
                m_rate = clampf(r); m_run = 1; m_k = 0; m_cnt = 0;
            end
        end else begin
            m_k++;
            exp_pulse = ((m_k * m_rate) / int'(HZ)) > (((m_k - 1) * m_rate) / int'(HZ));
            if (exp_pulse) m_cnt++;
            if (l) begin
                m_pend = clampf(r); m_pend_v = 1;
            end
            if (m_k == int'(HZ)) begin
                exp_wd = 1; m_sent = m_cnt; m_cnt = 0; m_k = 0;
                if (m_pend_v) begin
                    m_rate = m_pend; m_pend_v = 0;
                end
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare 1 time unit later.
    task automatic cyc(input bit l, input bit s, input int r, input string tag);
        load = l; stop = s; rate_in = CW'(r);
        @(posedge clk);
        model_edge(l, s, r);
        #1;
        if (pulse_out === 1'b1) obs_pulses++;
        check_outputs(tag);
        load = 1'b0; stop = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, tag);
    endtask

    initial begin
        // Reset values
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_outputs("reset");
        @(negedge clk); rst = 1'b1;
        idle_cycles(2, "idle");

        // Rate 3: pulses after E4, E7, E10, window repeats
        cyc(1, 0, 3, "r3_load");
        obs_pulses = 0;
        idle_cycles(10, "r3_w1");
        chk("r3_w1_count", 32'(obs_pulses), 32'd3);
        obs_pulses = 0;
        idle_cycles(10, "r3_w2");
        chk("r3_w2_count", 32'(obs_pulses), 32'd3);
        cyc(0, 1, 0, "r3_stop");

        // Rate 0: no pulses, window_done still fires
        cyc(1, 0, 0, "r0_load");
        obs_pulses = 0;
        idle_cycles(20, "r0_run");
        chk("r0_count", 32'(obs_pulses), 32'd0);
        cyc(0, 1, 0, "r0_stop");

        // Rate 25 clamps to one pulse per cycle
        cyc(1, 0, 25, "r25_load");
        obs_pulses = 0;
        idle_cycles(10, "r25_run");
        chk("r25_count", 32'(obs_pulses), 32'd10);
        cyc(0, 1, 0, "r25_stop");

        // Reload mid-window takes effect at the next boundary
        cyc(1, 0, 3, "chg_load3");
        obs_pulses = 0;
        idle_cycles(4, "chg_w1a");
        cyc(1, 0, 5, "chg_load5");
        idle_cycles(5, "chg_w1b");
        chk("chg_w1_count", 32'(obs_pulses), 32'd3);
        obs_pulses = 0;
        idle_cycles(10, "chg_w2");
        chk("chg_w2_count", 32'(obs_pulses), 32'd5);

        // Stop beats a simultaneous load
        idle_cycles(5, "stop_pre");
        cyc(1, 1, 7, "stop_load");
        obs_pulses = 0;
        idle_cycles(12, "stop_after");
        chk("stop_count", 32'(obs_pulses), 32'd0);

        // Asynchronous reset mid-window
        cyc(1, 0, 3, "rst_load");
        idle_cycles(5, "rst_pre");
        #3; rst = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(negedge clk); @(negedge clk); rst = 1'b1;
        cyc(1, 0, 3, "rst_reload");
        obs_pulses = 0;
        idle_cycles(10, "rst_win");
        chk("rst_win_count", 32'(obs_pulses), 32'd3);

        // Randomized loads, stops and rates
        for (int i = 0; i < 600; i++) begin
            bit l, s;
            l = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 59) == 0);
            cyc(l, s, int'($urandom_range(0, 31)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_rate_gen.md
# pulse_rate_gen

Programmable pulse-train generator and the transmit-side counterpart of the team's one-second event counter. It emits exactly `rate` single-cycle pulses per one-second window, spread as evenly as possible with a Bresenham accumulator. Its `pulse_out` drives the counter's input in loopback tests and is the board's calibrated frequency source.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per window; the window is one second at a 50 MHz clock.
- `CNT_W`, default 23: width of `rate_in` and `pulses_sent`.
- `TIMER_W`, default 26: window-timer width; must satisfy 2^TIMER_W > CLK_HZ.
- `ACC_W`, default 27: accumulator width; must satisfy 2^ACC_W > CLK_HZ + 2^CNT_W.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `rate_in`, input, CNT_W: requested pulses per window.
- `load`, input, 1: single-cycle strobe that samples `rate_in`.
- `stop`, input, 1: single-cycle strobe that aborts generation.
- `pulse_out`, output, 1: registered single-cycle output pulse.
- `window_done`, output, 1: registered single-cycle strobe on the last edge of each window.
- `busy`, output, 1: high in the RUN state.
- `pulses_sent`, output, CNT_W: number of pulses emitted in the last completed window.

## Operation
- States: IDLE and RUN.
- IDLE:
  - `load` latches `rate_in` into `rate` and clears `timer`, `acc` and the internal pulse count.
  - The next state is RUN.
- RUN, every edge:
  - Let `sum = acc + rate`, computed at ACC_W width.
  - If `sum >= CLK_HZ`: `acc <= sum - CLK_HZ`, `pulse_out <= 1`, and the pulse count increments.
  - Otherwise: `acc <= sum` and `pulse_out <= 0`.
  - `timer` increments.
- Window end, on the edge that processes `timer == CLK_HZ-1`:
  - `window_done <= 1`.
  - `pulses_sent <=` the final pulse count, including a pulse emitted on that same edge.
  - `timer`, `acc` and the pulse count clear.
  - If a pending load exists, `rate` takes the pending value and the pending flag clears.
  - The state stays RUN.
- `load` while in RUN stores `rate_in` as pending. A new `load` overwrites an existing pending value. Rate changes take effect only at a window boundary.
- `stop` in any state:
  - Next state is IDLE; `timer`, `acc`, pending and the count clear.
  - `pulse_out` and `window_done` are 0 on that edge.
  - `pulses_sent` holds its value.
- Simultaneous `load` and `stop`: `stop` wins and `load` is ignored.
- Rate boundaries:
  - `rate == 0`: no pulses are emitted; `window_done` still fires.
  - `rate >= CLK_HZ`: `rate` is clamped to CLK_HZ at latch time, giving one pulse per cycle.
- Invariant: `acc` equals 0 at every window end, so each window emits exactly `rate` pulses and there is no drift.

## Timing
- Reset values:
  - State is IDLE.
  - `pulse_out`, `window_done` and `busy` are 0.
  - `pulses_sent` is 0.
  - `rate`, `acc`, `timer` and pending are cleared.
- Reset asserted mid-window takes effect immediately, and the window is discarded.
- Latency, where edge E0 is the edge that samples `load` in IDLE:
  - `busy` is 1 after E0.
  - E1 processes `timer = 0`.
  - Window end falls on edge E(CLK_HZ); `window_done` is high for the cycle after that edge.
- Pulse spacing: the first pulse follows edge E(ceil(CLK_HZ/rate)). Gaps between pulses differ by at most one cycle.
- Windows run back-to-back with no idle cycle between them.

## Configuration
- Macro `PULSE_RATE_GEN_COUNT_EN`.
- Defined:
  - The internal pulse counter is built.
  - `pulses_sent` reports the count from the last completed window.
- Undefined:
  - The counter is not synthesised and `pulses_sent` is tied to 0.
  - `pulse_out`, `window_done` and all other behaviour are unchanged.

## Test plan
All scenarios use CLK_HZ=10.
- Load `rate_in=3` at E0 -> `pulse_out` high after E4, E7 and E10. `window_done` is high after E10 and `pulses_sent` becomes 3. The pattern repeats after E14, E17 and E20.
- Load `rate_in=0` -> `pulse_out` never asserts. `window_done` is high after E10 and E20, and `pulses_sent` stays 0.
- Load `rate_in=25` -> the rate is clamped and `pulse_out` is high after every edge from E1 onward. `pulses_sent` becomes 10 after E10.
- Running at rate 3, apply `load rate_in=5` at E5 -> the first window still emits 3 pulses. The second window emits pulses after E12, E14, E16, E18 and E20, and `pulses_sent` becomes 5 after E20.
- Running, assert `stop` together with `load` at E6 -> after E6 `busy` is 0. No further pulses or `window_done` occur, and `pulses_sent` keeps its prior value.
- Assert `rst` low mid-window -> all outputs go to 0 immediately. After release, a new load restarts cleanly with a full 3-pulse window.
